adc_sample_capture: RTL and testbench
=====================================

Name: adc_sample_capture

Overview:
- Sits directly downstream of the serial ADC front end in the audio equalizer datapath, in the system clk_i domain.
- Detects each end-of-conversion on the ADC chip-select line and captures the parallel 12-bit sample.
- Optionally converts the sample from offset-binary to two's complement.
- Buffers samples in a small FIFO and presents them to the filter bank over a valid/ready handshake.

Parameters:
- DATA_W, 12: sample width, matching the ADC parallel output.
- ADDR_W, 4: FIFO address width; depth = 2**ADDR_W = 16.
- SYNC_STAGES, 2: synchronizer flops on cs_i and data_i; minimum 2.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-low reset.
- cs_i  in  1  ADC chip-select; a rising edge marks conversion complete.
- data_i  in  DATA_W  ADC parallel sample; stable while cs_i is high.
- signed_en_i  in  1  1 = invert MSB (offset-binary to two's complement); 0 = pass through unchanged.
- ready_i  in  1  consumer accepts the head sample.
- clr_ovf_i  in  1  clears overflow_o.
- valid_o  out  1  FIFO not empty.
- data_o  out  DATA_W  head-of-FIFO sample (show-ahead).
- level_o  out  ADDR_W+1  FIFO occupancy, 0..16.
- overflow_o  out  1  sticky; a sample was dropped because the FIFO was full.

Behaviour:
- Reset (rst_i low, asynchronous):
  - valid_o=0, data_o=0, level_o=0, overflow_o=0.
  - FIFO pointers = 0.
  - cs synchronizer chain and its edge-delay flop preset to 1, so a cs_i held high through reset does not create a spurious capture.
  - data synchronizer chain cleared to 0.
- Reset mid-operation: FIFO contents discarded, any pending write cancelled.
- Synchronization: cs_i and data_i each pass through SYNC_STAGES flops. cs_s is the last stage; cs_d is cs_s delayed one cycle.
- Capture:
  - cap = cs_s & ~cs_d.
  - On cap, register smp = data_sync ^ (signed_en_i ? 12'h800 : 0), using signed_en_i as sampled that cycle.
  - Assert wr_pend for exactly one cycle.
  - Only rising edges capture. A cs_i pulse shorter than one clk_i period may be missed; this is legal, because ADC frames are many clk_i cycles long.
- Write: when wr_pend=1, smp is written at the write pointer on the next edge.
- Latency: with an empty FIFO, valid_o rises on the 4th clk_i rising edge after the first edge that samples cs_i high (SYNC_STAGES=2). data_o equals the captured value in that same cycle.
- Pop: occurs when valid_o & ready_i. The read pointer advances, and data_o shows the next entry in the following cycle.
- ready_i with valid_o=0: ignored, no pointer change.
- Full (level_o=16) with wr_pend:
  - If pop also occurs that cycle: the write is accepted and level_o stays 16.
  - Otherwise: the sample is dropped, pointers are unchanged, and overflow_o is set on the next edge.
- Empty with wr_pend and ready_i: no bypass. The sample appears on valid_o next cycle and the pop is ignored this cycle.
- Simultaneous push and pop when not full: level_o unchanged.
- Pointers: ADDR_W+1 bits. They wrap modulo 32, and the FIFO index is the lower ADDR_W bits.
  - full when the MSBs differ and the lower bits are equal.
  - empty when the pointers are equal.
  - level_o = wr_ptr - rd_ptr.
- overflow_o: cleared by clr_ovf_i. If set and clear occur in the same cycle, set wins.
- signed_en_i change: affects only samples captured after the change. Stored samples are not reconverted.

Decomposition:
- Package adc_cap_pkg:
  - DATA_W and ADDR_W defaults
  - SIGN_FLIP = 12'h800
  - FIFO_DEPTH = 1<<ADDR_W
- Sub-module sync_fifo_sa:
  - show-ahead FIFO with push/pop/full/empty/level and drop-on-full flag.
  - Instantiated once; synchronizer and capture logic live in the top.

Test Plan:
- Reset with cs_i=1 held, then release rst_i → no capture, valid_o=0, level_o=0 for 20 cycles.
- cs_i 0→1 with data_i=12'h800, signed_en_i=1 → valid_o high 4 edges later, data_o=12'h000; with signed_en_i=0 → data_o=12'h800.
- 3 conversions with data 12'h001, 12'hFFF, 12'h7FF, signed_en_i=1, ready_i=0 → level_o=3; then ready_i=1 → data_o sequence 12'h801, 12'h7FF, 12'hFFF on consecutive cycles, then valid_o=0.
- 17 conversions, ready_i=0 → level_o=16, overflow_o=1, first 16 samples popped in order, 17th absent; clr_ovf_i pulse → overflow_o=0.
- FIFO full and ready_i=1 in the write cycle → level_o stays 16, overflow_o stays 0, new sample read out 16th.
- rst_i low asynchronously with level_o=5 and a capture in flight → outputs zero immediately; after release, no stale sample appears.

Source files
------------

// File: rtl/adc_cap_pkg.sv
// Shared constants for the ADC sample capture block.
package adc_cap_pkg;

  localparam int unsigned DATA_W     = 12;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned FIFO_DEPTH = 1 << ADDR_W;

  // XOR mask that turns an offset-binary sample into two's complement.
  localparam logic [DATA_W-1:0] SIGN_FLIP = 12'h800;

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO; a push while full (with no pop) is dropped and flagged.
module sync_fifo_sa #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   level_o,
  output logic              drop_o
);

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [1 << ADDR_W];
  logic              full;
  logic              do_push;
  logic              do_pop;

  always_comb begin
    full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
              (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    empty_o = (wr_ptr_q == rd_ptr_q);
    do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot the push needs.
    do_push = push_i & (~full | do_pop);
    drop_o  = push_i & full & ~do_pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    level_o = wr_ptr_q - rd_ptr_q;
    data_o  = empty_o ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/adc_sample_capture.sv
// Captures ADC samples on each chip-select rising edge, optionally converts them to
// two's complement, and queues them for the filter bank.
module adc_sample_capture #(
  parameter int unsigned DATA_W      = adc_cap_pkg::DATA_W,
  parameter int unsigned ADDR_W      = adc_cap_pkg::ADDR_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cs_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              signed_en_i,
  input  logic              ready_i,
  input  logic              clr_ovf_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W:0]   level_o,
  output logic              overflow_o
);

  import adc_cap_pkg::SIGN_FLIP;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   cs_d_q;
  logic                   cs_s;
  logic [DATA_W-1:0]      data_sync_q [SYNC_STAGES];
  logic [DATA_W-1:0]      data_sync_d [SYNC_STAGES];
  logic                   cap;
  logic [DATA_W-1:0]      smp_q, smp_d;
  logic                   wr_pend_q, wr_pend_d;
  logic                   overflow_q, overflow_d;
  logic                   fifo_empty;
  logic                   fifo_drop;

  always_comb begin
    cs_sync_d      = {cs_sync_q[SYNC_STAGES-2:0], cs_i};
    data_sync_d[0] = data_i;
    for (int i = 1; i < SYNC_STAGES; i++) data_sync_d[i] = data_sync_q[i-1];

    cs_s      = cs_sync_q[SYNC_STAGES-1];
    cap       = cs_s & ~cs_d_q;
    wr_pend_d = cap;
    smp_d     = smp_q;
    if (cap) smp_d = data_sync_q[SYNC_STAGES-1] ^ (signed_en_i ? SIGN_FLIP : '0);

    // Set wins over clear so a drop in the clearing cycle is never lost.
    overflow_d = overflow_q;
    if (clr_ovf_i) overflow_d = 1'b0;
    if (fifo_drop) overflow_d = 1'b1;
  end

  // cs chain presets high so a cs_i held high through reset is not seen as an edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cs_sync_q  <= '1;
      cs_d_q     <= 1'b1;
      smp_q      <= '0;
      wr_pend_q  <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
    end else begin
      cs_sync_q  <= cs_sync_d;
      cs_d_q     <= cs_s;
      smp_q      <= smp_d;
      wr_pend_q  <= wr_pend_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_d[i];
    end
  end

  sync_fifo_sa #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (wr_pend_q),
    .data_i  (smp_q),
    .pop_i   (ready_i),
    .data_o  (data_o),
    .empty_o (fifo_empty),
    .level_o (level_o),
    .drop_o  (fifo_drop)
  );

  assign valid_o    = ~fifo_empty;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_adc_sample_capture.sv
// Directed self-checking bench for adc_sample_capture.
module tb_adc_sample_capture;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cs_i;
  logic [11:0] data_i;
  logic        signed_en_i;
  logic        ready_i;
  logic        clr_ovf_i;
  logic        valid_o;
  logic [11:0] data_o;
  logic [4:0]  level_o;
  logic        overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  adc_sample_capture u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cs_i        (cs_i),
    .data_i      (data_i),
    .signed_en_i (signed_en_i),
    .ready_i     (ready_i),
    .clr_ovf_i   (clr_ovf_i),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .level_o     (level_o),
    .overflow_o  (overflow_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One conversion: cs low 3 cycles with new data, then high. Returns at the 3rd
  // rising edge after cs goes high, so the FIFO write lands on the next edge.
  task automatic convert(input logic [11:0] d);
    @(posedge clk_i);
    #1 cs_i = 1'b0;
    data_i = d;
    repeat (3) @(posedge clk_i);
    #1 cs_i = 1'b1;
    repeat (3) @(posedge clk_i);
  endtask

  logic [11:0] exp3 [3];

  initial begin
    rst_i       = 1'b0;
    cs_i        = 1'b1;
    data_i      = '0;
    signed_en_i = 1'b0;
    ready_i     = 1'b0;
    clr_ovf_i   = 1'b0;

    // Reset values with cs held high, then no spurious capture after release.
    #23;
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_level", level_o, 0);
    check("rst_ovf", overflow_o, 0);
    rst_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      check("no_spurious_valid", valid_o, 0);
      check("no_spurious_level", level_o, 0);
    end

    // Latency and sign conversion of 12'h800.
    for (int s = 1; s >= 0; s--) begin
      @(posedge clk_i);
      #1 cs_i = 1'b0;
      data_i = 12'h800;
      signed_en_i = s[0];
      repeat (3) @(posedge clk_i);
      #1 cs_i = 1'b1;
      for (int e = 1; e <= 4; e++) begin
        @(posedge clk_i);
        @(negedge clk_i);
        check("latency_valid", valid_o, (e == 4) ? 1 : 0);
      end
      check("sign_data", data_o, s ? 12'h000 : 12'h800);
      ready_i = 1'b1;
      @(negedge clk_i);
      ready_i = 1'b0;
      check("pop_to_empty", valid_o, 0);
    end

    // Three samples, two's complement, popped back to back.
    signed_en_i = 1'b1;
    convert(12'h001);
    convert(12'hFFF);
    convert(12'h7FF);
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("level3", level_o, 3);
    exp3[0] = 12'h801;
    exp3[1] = 12'h7FF;
    exp3[2] = 12'hFFF;
    ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("seq3_valid", valid_o, 1);
      check("seq3_data", data_o, exp3[k]);
      @(negedge clk_i);
    end
    ready_i = 1'b0;
    check("seq3_empty", valid_o, 0);

    // Overflow: 17 samples, the last is dropped.
    signed_en_i = 1'b0;
    for (int i = 0; i < 17; i++) convert(12'h100 + 12'(i));
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("full_level", level_o, 16);
    check("ovf_set", overflow_o, 1);
    ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ovf_order", data_o, 12'h100 + 12'(i));
      @(negedge clk_i);
    end
    ready_i = 1'b0;
    check("ovf_17th_absent", valid_o, 0);
    check("ovf_sticky", overflow_o, 1);
    clr_ovf_i = 1'b1;
    @(negedge clk_i);
    clr_ovf_i = 1'b0;
    check("ovf_cleared", overflow_o, 0);

    // Full with a pop in the write cycle: write accepted, no overflow.
    for (int i = 0; i < 16; i++) convert(12'h200 + 12'(i));
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("full2_level", level_o, 16);
    convert(12'h2AA);
    #1 ready_i = 1'b1;
    @(posedge clk_i);
    #1 ready_i = 1'b0;
    @(negedge clk_i);
    check("push_pop_full_level", level_o, 16);
    check("push_pop_full_ovf", overflow_o, 0);
    ready_i = 1'b1;
    for (int i = 1; i < 17; i++) begin
      check("push_pop_full_order", data_o, (i == 16) ? 12'h2AA : 12'h200 + 12'(i));
      @(negedge clk_i);
    end
    ready_i = 1'b0;
    check("push_pop_full_empty", valid_o, 0);

    // Asynchronous reset with 5 stored samples and a write pending.
    for (int i = 0; i < 5; i++) convert(12'h300 + 12'(i));
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("pre_rst_level", level_o, 5);
    convert(12'h3AA);
    #3 rst_i = 1'b0;
    #1;
    check("async_rst_valid", valid_o, 0);
    check("async_rst_data", data_o, 0);
    check("async_rst_level", level_o, 0);
    check("async_rst_ovf", overflow_o, 0);
    #3 rst_i = 1'b1;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    check("post_rst_valid", valid_o, 0);
    check("post_rst_level", level_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
